// File: rtl/canny_pkg.sv
// Shared types and constants for the edge-detector memory path: loader FSM
// states, bank numbering and default frame geometry.
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } load_state_e;

    localparam int NUM_BANKS = 9;

    // Bank index = (y mod 3) * 3 + (x mod 3); bank a holds the (0,0) phase.
    typedef enum logic [3:0] {
        BANK_A = 4'd0,
        BANK_B = 4'd1,
        BANK_C = 4'd2,
        BANK_D = 4'd3,
        BANK_E = 4'd4,
        BANK_F = 4'd5,
        BANK_G = 4'd6,
        BANK_H = 4'd7,
        BANK_I = 4'd8
    } bank_e;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [3:0] idx);
        logic [NUM_BANKS-1:0] oh;
        oh = '0;
        if (idx <= BANK_I) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/image_loader_interleave_counter.sv
// Raster-position tracker for the 3x3 bank interleave: keeps x/y, their mod-3
// phases, the per-bank column and the bank-row base using counters only.
module interleave_counter
    import canny_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int BANK_COLS = (IMG_W + 2) / 3,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              advance,
    output logic [3:0]        bank_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_pixel_o
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        xm3_q, xm3_d;
    logic [1:0]        ym3_q, ym3_d;
    logic [ADDR_W-1:0] xcol_q, xcol_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        xm3_d     = xm3_q;
        ym3_d     = ym3_q;
        xcol_d    = xcol_q;
        rowbase_d = rowbase_q;
        if (clear) begin
            x_d       = '0;
            y_d       = '0;
            xm3_d     = '0;
            ym3_d     = '0;
            xcol_d    = '0;
            rowbase_d = '0;
        end else if (advance) begin
            if (x_q == XW'(IMG_W - 1)) begin
                x_d    = '0;
                xm3_d  = '0;
                xcol_d = '0;
                y_d    = y_q + 1'b1;
                // Every third image row starts a new row of bank words.
                if (ym3_q == 2'd2) begin
                    ym3_d     = '0;
                    rowbase_d = rowbase_q + ADDR_W'(BANK_COLS);
                end else begin
                    ym3_d = ym3_q + 2'd1;
                end
            end else begin
                x_d = x_q + 1'b1;
                if (xm3_q == 2'd2) begin
                    xm3_d  = '0;
                    xcol_d = xcol_q + 1'b1;
                end else begin
                    xm3_d = xm3_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q       <= '0;
            y_q       <= '0;
            xm3_q     <= '0;
            ym3_q     <= '0;
            xcol_q    <= '0;
            rowbase_q <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            xm3_q     <= xm3_d;
            ym3_q     <= ym3_d;
            xcol_q    <= xcol_d;
            rowbase_q <= rowbase_d;
        end
    end

    assign bank_o       = {2'b00, ym3_q} + {1'b0, ym3_q, 1'b0} + {2'b00, xm3_q};
    assign addr_o       = rowbase_q + xcol_q;
    assign last_pixel_o = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

endmodule

// File: rtl/image_loader.sv
// Streams a raster-order pixel frame into the nine interleaved read SRAMs,
// one registered write per accepted pixel, with back-pressure from the banks.
module image_loader
    import canny_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int BANK_COLS = (IMG_W + 2) / 3,
    parameter int ADDR_W    = 19
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load_start,
    input  logic [7:0]           pixel_in,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    input  logic                 bank_stall,
    output logic [NUM_BANKS-1:0] bank_we,
    output logic [ADDR_W-1:0]    bank_addr,
    output logic [7:0]           bank_data,
    output logic                 busy,
    output logic                 load_done,
    output logic                 error
);

    localparam int MAX_ADDR = ((IMG_H + 2) / 3) * BANK_COLS - 1;

    generate
        if (IMG_W < 3 || IMG_H < 3) begin : g_dim_chk
            $error("image_loader: IMG_W and IMG_H must be at least 3");
        end
        if (MAX_ADDR >= (1 << ADDR_W)) begin : g_addr_chk
            $error("image_loader: ADDR_W too narrow for the frame");
        end
    endgenerate

    load_state_e          state_q;
    logic [NUM_BANKS-1:0] we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    logic              handshake;
    logic [3:0]        cnt_bank;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;

    assign pixel_ready = (state_q == LOAD) && !bank_stall;
    assign handshake   = pixel_valid && pixel_ready;

    interleave_counter #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .BANK_COLS(BANK_COLS),
        .ADDR_W   (ADDR_W)
    ) u_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       ((state_q == IDLE) && load_start),
        .advance     (handshake),
        .bank_o      (cnt_bank),
        .addr_o      (cnt_addr),
        .last_pixel_o(cnt_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A stalled write stays on the bus untouched until the banks take it.
            if (!bank_stall) begin
                we_q <= handshake ? bank_onehot(cnt_bank) : '0;
                if (handshake) begin
                    addr_q <= cnt_addr;
                    data_q <= pixel_in;
                end
            end
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) error_q <= 1'b1;
                    if (handshake && cnt_last) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (load_start) error_q <= 1'b1;
                    if (!bank_stall) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bank_we   = we_q;
    assign bank_addr = addr_q;
    assign bank_data = data_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader on a 6x6 frame: scoreboarded writes against a
// divide-based reference, plus stall, restart, mid-frame reset and idle cases.
module tb_image_loader;

    localparam int W    = 6;
    localparam int H    = 6;
    localparam int BC   = 2;
    localparam int AW   = 19;
    localparam int NPIX = W * H;

    logic          clk         = 1'b0;
    logic          n_rst       = 1'b0;
    logic          load_start  = 1'b0;
    logic [7:0]    pixel_in    = 8'd0;
    logic          pixel_valid = 1'b0;
    logic          bank_stall  = 1'b0;
    logic          pixel_ready;
    logic [8:0]    bank_we;
    logic [AW-1:0] bank_addr;
    logic [7:0]    bank_data;
    logic          busy;
    logic          load_done;
    logic          error;

    image_loader #(
        .IMG_W    (W),
        .IMG_H    (H),
        .BANK_COLS(BC),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_start (load_start),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .bank_stall (bank_stall),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_data  (bank_data),
        .busy       (busy),
        .load_done  (load_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] m_we(input int p);
        int x;
        int y;
        x = p % W;
        y = p / W;
        return 9'd1 << ((y % 3) * 3 + (x % 3));
    endfunction

    function automatic logic [AW-1:0] m_addr(input int p);
        return AW'(((p / W) / 3) * BC + (p % W) / 3);
    endfunction

    typedef struct packed {
        logic [8:0]    we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           sb_e;
    int            hs_idx      = 0;
    int            wr_cnt      = 0;
    int            cyc         = 0;
    int            last_hs_cyc = 0;
    int            done_cyc    = 0;
    int            done_cnt    = 0;
    logic [8:0]    cap_we  [NPIX];
    logic [AW-1:0] cap_addr[NPIX];
    logic [7:0]    cap_data[NPIX];

    always @(posedge clk) cyc++;

    // Writes are consumed before this cycle's handshake is queued, so a write
    // must show up on the cycle after its pixel was accepted.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bank_we != 9'd0 && !bank_stall) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", 32'(bank_we), 32'h0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_we", 32'(bank_we), 32'(sb_e.we));
                    check("sb_addr", 32'(bank_addr), 32'(sb_e.addr));
                    check("sb_data", 32'(bank_data), 32'(sb_e.data));
                    if (wr_cnt < NPIX) begin
                        cap_we[wr_cnt]   = bank_we;
                        cap_addr[wr_cnt] = bank_addr;
                        cap_data[wr_cnt] = bank_data;
                    end
                    wr_cnt++;
                end
            end
            if (pixel_valid && pixel_ready) begin
                exp_q.push_back(wr_t'{we: m_we(hs_idx), addr: m_addr(hs_idx), data: 8'(hs_idx)});
                if (hs_idx == NPIX - 1) last_hs_cyc = cyc;
                hs_idx++;
            end
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk);
        #1;
        load_start  = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'hAA;
        hs_idx      = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        exp_q.delete();
        @(negedge clk);
        check("start_ready", 32'(pixel_ready), 32'h0);
        @(posedge clk);
        #1;
        load_start = 1'b0;
        check("start_err_clr", 32'(error), 32'h0);
    endtask

    task automatic run_frame(input string name, input int stall_at, input int restart_at,
                             input int rst_at, input bit gaps);
        int p          = 0;
        int guard      = 0;
        int stall_left = 0;
        bit stalled    = 1'b0;
        bit restarted  = 1'b0;
        bit chk_err    = 1'b0;
        start_frame();
        while (p < NPIX && guard < 400) begin
            guard++;
            pixel_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pixel_in    = 8'(p);
            if (!stalled && p == stall_at + 1) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            bank_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            load_start = (!restarted && p == restart_at);
            if (load_start) restarted = 1'b1;
            if (p == rst_at) begin
                n_rst = 1'b0;
                #1;
                check("rst_ready", 32'(pixel_ready), 32'h0);
                check("rst_we", 32'(bank_we), 32'h0);
                check("rst_addr", 32'(bank_addr), 32'h0);
                check("rst_data", 32'(bank_data), 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
                check("rst_error", 32'(error), 32'h0);
                pixel_valid = 1'b0;
                @(posedge clk);
                #1;
                n_rst = 1'b1;
                exp_q.delete();
                $display("frame %s: reset at pixel %0d", name, p);
                return;
            end
            @(negedge clk);
            if (bank_stall) begin
                check("stall_ready", 32'(pixel_ready), 32'h0);
                check("stall_we", 32'(bank_we), 32'(m_we(stall_at)));
                check("stall_addr", 32'(bank_addr), 32'(m_addr(stall_at)));
                check("stall_data", 32'(bank_data), 32'(stall_at));
            end
            if (chk_err) begin
                check("err_set", 32'(error), 32'h1);
                chk_err = 1'b0;
            end
            if (load_start) chk_err = 1'b1;
            if (pixel_valid && pixel_ready) p++;
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
        bank_stall  = 1'b0;
        load_start  = 1'b0;
        check("frame_in_time", 32'(guard < 400), 32'h1);
        guard = 0;
        while (done_cnt == 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'h1);
        check("done_latency", 32'(done_cyc - last_hs_cyc), 32'h2);
        check("write_count", 32'(wr_cnt), 32'(NPIX));
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("busy_idle", 32'(busy), 32'h0);
        $display("frame %s: %0d writes, load_done at +%0d", name, wr_cnt, done_cyc - last_hs_cyc);
    endtask

    task automatic check_corners();
        check("p0_we", 32'(cap_we[0]), 32'h001);
        check("p0_addr", 32'(cap_addr[0]), 32'h0);
        check("p0_data", 32'(cap_data[0]), 32'h0);
        check("p4_we", 32'(cap_we[4]), 32'h002);
        check("p4_addr", 32'(cap_addr[4]), 32'h1);
        check("p18_we", 32'(cap_we[18]), 32'h001);
        check("p18_addr", 32'(cap_addr[18]), 32'h2);
        check("p35_we", 32'(cap_we[35]), 32'h100);
        check("p35_addr", 32'(cap_addr[35]), 32'h3);
        check("p35_data", 32'(cap_data[35]), 32'd35);
    endtask

    initial begin
        @(posedge clk);
        #2;
        check("reset_ready", 32'(pixel_ready), 32'h0);
        check("reset_we", 32'(bank_we), 32'h0);
        check("reset_addr", 32'(bank_addr), 32'h0);
        check("reset_data", 32'(bank_data), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(load_done), 32'h0);
        check("reset_error", 32'(error), 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Valid pixels while idle must be refused and leave no trace.
        pixel_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixel_in = 8'(i);
            @(negedge clk);
            check("idle_ready", 32'(pixel_ready), 32'h0);
            check("idle_we", 32'(bank_we), 32'h0);
            check("idle_error", 32'(error), 32'h0);
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
        $display("idle: 5 cycles of pixel_valid refused");

        run_frame("plain", 100, -1, -1, 1'b0);
        check_corners();

        run_frame("stall", 7, -1, -1, 1'b0);

        run_frame("restart", 100, 10, -1, 1'b0);
        check("err_sticky", 32'(error), 32'h1);

        run_frame("after_err", 100, -1, -1, 1'b0);
        check("err_cleared", 32'(error), 32'h0);

        run_frame("reset", 100, -1, 20, 1'b0);
        run_frame("post_reset", 100, -1, -1, 1'b0);
        check_corners();

        run_frame("gaps", 100, -1, -1, 1'b1);
        check_corners();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
